inst_fetch_arb: RTL and testbench
=================================

INST_FETCH_ARB -- requirements
Module: inst_fetch_arb

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REQ, 2, number of fetch requesters sharing the memory port (2..4)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on its posedge
  rst  in  bool_t  synchronous, active-high reset
  req  in  core::inst_fetch_req_t[NUM_REQ]  per-requester fetch request (pc, en)
  rsp  out  core::inst_fetch_rsp_t[NUM_REQ]  per-requester fetch response (inst, done)
  mem_req  out  core::inst_fetch_req_t  request to the shared instruction memory
  mem_rsp  in  core::inst_fetch_rsp_t  response from the shared instruction memory
  gnt  out  NUM_REQ  one-hot index of the granted requester; all-zero when idle
  busy  out  bool_t  a memory fetch is in flight
REQ-003 The block SHALL have one clock domain, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have two states, IDLE and BUSY, with registered state, grant index g, latched pc lpc and round-robin pointer ptr.
REQ-005 In IDLE with any req[i].en=1, the block SHALL select the first asserted i, searching circularly from ptr, and latch g=i and lpc=req[i].pc; the next state SHALL be BUSY.
REQ-006 In IDLE with no req[i].en asserted, the block SHALL stay in IDLE, and ptr SHALL be unchanged.
REQ-007 In BUSY, mem_req.en SHALL be 1 and mem_req.pc SHALL be lpc; in IDLE, mem_req.en SHALL be 0 and mem_req.pc SHALL be 0.
REQ-008 gnt SHALL be one-hot at bit g, and busy SHALL be 1, exactly while in BUSY.
REQ-009 In BUSY with mem_rsp.done=1 and no abort (REQ-011), rsp[g].done SHALL be 1 and rsp[g].inst SHALL be mem_rsp.inst in that same cycle (combinational forward).
REQ-010 On that completion, ptr SHALL become (g+1) mod NUM_REQ and the next state SHALL be IDLE.
REQ-011 In BUSY, if req[g].en=0 or req[g].pc != lpc, this SHALL be an abort:
  - rsp[g].done SHALL be 0 that cycle, even if mem_rsp.done=1;
  - the next state SHALL be IDLE;
  - ptr SHALL be unchanged, so the aborting requester keeps its priority.
REQ-012 rsp[j].done SHALL be 0 and rsp[j].inst SHALL be 0 for every j != g, and for all j when in IDLE.
REQ-013 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle N, done returned at N+1 at the earliest.
REQ-014 Requests from non-granted requesters SHALL be ignored while in BUSY; requesters hold en until done.
REQ-015 A new request SHALL be arbitrated only in the cycle after completion or abort, so back-to-back fetches take at least 2 cycles each.
REQ-016 With NUM_REQ requesters continuously asserting en, each SHALL be granted once every NUM_REQ fetches (no starvation).

Reset
REQ-017 rst=1 at a posedge SHALL set state=IDLE, g=0, lpc=0 and ptr=0.
REQ-018 During and after reset, all outputs SHALL be 0 until a grant occurs.
REQ-019 rst asserted mid-fetch SHALL drop mem_req.en the next cycle; a mem_rsp.done arriving in the reset cycle SHALL be discarded.
REQ-020 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-021 Single requester:
  - stimulus: req[0]={pc=0x100,en=1}, mem_rsp.done=1 two cycles later with inst=0x00000013;
  - response: mem_req={0x100,1} one cycle after req; rsp[0]={0x00000013,1} for one cycle; gnt=01 then 00.
REQ-022 Contention:
  - stimulus: req[0]={0x100,1} and req[1]={0x200,1} held; memory 1-cycle done each fetch;
  - response: grants alternate 0,1,0,1; mem_req.pc alternates 0x100/0x200; rsp[1].done=0 whenever gnt=01.
REQ-023 Abort by en drop:
  - stimulus: grant to req[1]; req[1].en=0 in the same cycle as mem_rsp.done=1;
  - response: rsp[1].done=0; IDLE next cycle; a subsequent req[1] is still granted first (ptr unchanged).
REQ-024 Abort by pc change:
  - stimulus: grant with lpc=0x100; req[0].pc changes to 0x140 while BUSY;
  - response: abort; re-grant with mem_req.pc=0x140 two cycles later.
REQ-025 Reset mid-fetch:
  - stimulus: rst=1 while BUSY with mem_rsp.done=1;
  - response: all rsp.done=0, busy=0, gnt=0 next cycle; ptr=0.

Source files
------------

// File: rtl/inst_fetch_arb.sv
// inst_fetch_arb: round-robin arbiter sharing one instruction memory port among NUM_REQ fetch requesters.
module inst_fetch_arb #(
   parameter int NUM_REQ = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0][31:0] req_pc,
   input  logic [NUM_REQ-1:0]       req_en,
   output logic [NUM_REQ-1:0][31:0] rsp_inst,
   output logic [NUM_REQ-1:0]       rsp_done,
   output logic [31:0]              mem_req_pc,
   output logic                     mem_req_en,
   input  logic [31:0]              mem_rsp_inst,
   input  logic                     mem_rsp_done,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t st;
   logic [IW-1:0] g, ptr, sel;
   logic [31:0] lpc, sel_pc, cur_pc;
   logic any, cur_en, abort, fin;
   int idx;
   always_comb begin
      sel = ptr;
      sel_pc = '0;
      any = 1'b0;
      cur_en = 1'b0;
      cur_pc = '0;
      idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!any && req_en[idx]) begin
            any = 1'b1;
            sel = IW'(idx);
            sel_pc = req_pc[idx];
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (g == IW'(j)) begin
            cur_en = req_en[j];
            cur_pc = req_pc[j];
         end
      end
      abort = st == BUSY && (!cur_en || cur_pc != lpc);
      // a done arriving together with reset is discarded
      fin = st == BUSY && mem_rsp_done && !abort && !rst;
   end
   assign busy = st == BUSY;
   assign mem_req_en = busy;
   assign mem_req_pc = busy ? lpc : '0;
   always_comb begin
      for (int j = 0; j < NUM_REQ; j++) begin
         gnt[j] = busy && g == IW'(j);
         rsp_done[j] = fin && g == IW'(j);
         rsp_inst[j] = rsp_done[j] ? mem_rsp_inst : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         g <= '0;
         lpc <= '0;
         ptr <= '0;
      end else if (st == IDLE) begin
         if (any) begin
            st <= BUSY;
            g <= sel;
            lpc <= sel_pc;
         end
      end else if (abort) begin
         st <= IDLE;
      end else if (mem_rsp_done) begin
         st <= IDLE;
         ptr <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
      end
   end
endmodule

// File: tb/tb_inst_fetch_arb.sv
// tb_inst_fetch_arb: directed checks of arbitration, completion, aborts and reset.
module tb_inst_fetch_arb;
   logic clk = 1'b0;
   logic rst;
   logic [1:0][31:0] req_pc;
   logic [1:0] req_en;
   logic [1:0][31:0] rsp_inst;
   logic [1:0] rsp_done;
   logic [31:0] mem_req_pc;
   logic mem_req_en;
   logic [31:0] mem_rsp_inst;
   logic mem_rsp_done;
   logic [1:0] gnt;
   logic busy;
   int total = 0;
   int bad = 0;

   inst_fetch_arb #(.NUM_REQ(2)) dut (
      .clk(clk), .rst(rst), .req_pc(req_pc), .req_en(req_en),
      .rsp_inst(rsp_inst), .rsp_done(rsp_done),
      .mem_req_pc(mem_req_pc), .mem_req_en(mem_req_en),
      .mem_rsp_inst(mem_rsp_inst), .mem_rsp_done(mem_rsp_done),
      .gnt(gnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_en = '0;
      req_pc = '0;
      mem_rsp_done = 1'b0;
      mem_rsp_inst = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (mem_req_en !== 1'b0 || mem_req_pc !== 32'h0) begin bad++; $display("FAIL reset_mem_req got=%b/%h exp=0/0", mem_req_en, mem_req_pc); end
      total++; if (rsp_done !== 2'b00 || rsp_inst !== 64'h0) begin bad++; $display("FAIL reset_rsp got=%b/%h exp=00/0", rsp_done, rsp_inst); end
   endtask

   task automatic test_single();
      tick();
      req_en = 2'b01;
      req_pc[0] = 32'h100;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
      tick();
      #1;
      total++; if (mem_req_en !== 1'b1 || mem_req_pc !== 32'h100) begin bad++; $display("FAIL single_mem_req got=%b/%h exp=1/100", mem_req_en, mem_req_pc); end
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b exp=01", gnt); end
      total++; if (rsp_done !== 2'b00) begin bad++; $display("FAIL single_early_done got=%b exp=00", rsp_done); end
      tick();
      mem_rsp_done = 1'b1;
      mem_rsp_inst = 32'h00000013;
      #1;
      total++; if (rsp_done !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", rsp_done); end
      total++; if (rsp_inst[0] !== 32'h13 || rsp_inst[1] !== 32'h0) begin bad++; $display("FAIL single_inst got=%h/%h exp=13/0", rsp_inst[0], rsp_inst[1]); end
      tick();
      req_en = 2'b00;
      mem_rsp_done = 1'b0;
      #1;
      total++; if (gnt !== 2'b00 || busy !== 1'b0 || rsp_done !== 2'b00) begin bad++; $display("FAIL single_after gnt=%b busy=%b done=%b exp=00/0/00", gnt, busy, rsp_done); end
   endtask

   task automatic test_contention();
      logic [1:0] eg;
      logic [31:0] ep;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_en = 2'b11;
      req_pc[0] = 32'h100;
      req_pc[1] = 32'h200;
      mem_rsp_done = 1'b1;
      mem_rsp_inst = 32'hAAAA0001;
      for (int f = 0; f < 4; f++) begin
         eg = (f % 2 == 1) ? 2'b10 : 2'b01;
         ep = (f % 2 == 1) ? 32'h200 : 32'h100;
         #1;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle_%0d busy got=%b exp=0", f, busy); end
         tick();
         #1;
         total++; if (gnt !== eg) begin bad++; $display("FAIL cont_gnt_%0d got=%b exp=%b", f, gnt, eg); end
         total++; if (mem_req_pc !== ep) begin bad++; $display("FAIL cont_pc_%0d got=%h exp=%h", f, mem_req_pc, ep); end
         total++; if (rsp_done !== eg) begin bad++; $display("FAIL cont_done_%0d got=%b exp=%b", f, rsp_done, eg); end
         tick();
      end
      req_en = 2'b00;
      mem_rsp_done = 1'b0;
   endtask

   task automatic test_abort_en();
      req_en = 2'b01;
      req_pc[0] = 32'h100;
      tick();
      mem_rsp_done = 1'b1;
      tick();
      req_en = 2'b10;
      req_pc[1] = 32'h200;
      mem_rsp_done = 1'b0;
      tick();
      #1;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL abort_en_gnt got=%b exp=10", gnt); end
      req_en = 2'b00;
      mem_rsp_done = 1'b1;
      mem_rsp_inst = 32'hDEAD0001;
      #1;
      total++; if (rsp_done !== 2'b00 || rsp_inst !== 64'h0) begin bad++; $display("FAIL abort_en_done got=%b/%h exp=00/0", rsp_done, rsp_inst); end
      tick();
      mem_rsp_done = 1'b0;
      req_en = 2'b11;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_en_idle busy got=%b exp=0", busy); end
      tick();
      #1;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL abort_en_keep_prio got=%b exp=10", gnt); end
      mem_rsp_done = 1'b1;
      mem_rsp_inst = 32'h0000BEEF;
      #1;
      total++; if (rsp_done !== 2'b10 || rsp_inst[1] !== 32'hBEEF) begin bad++; $display("FAIL abort_en_regrant_done got=%b/%h exp=10/0000beef", rsp_done, rsp_inst[1]); end
      tick();
      req_en = 2'b00;
      mem_rsp_done = 1'b0;
   endtask

   task automatic test_abort_pc();
      req_en = 2'b01;
      req_pc[0] = 32'h100;
      tick();
      #1;
      total++; if (mem_req_pc !== 32'h100) begin bad++; $display("FAIL abort_pc_first got=%h exp=100", mem_req_pc); end
      req_pc[0] = 32'h140;
      mem_rsp_done = 1'b1;
      #1;
      total++; if (rsp_done !== 2'b00) begin bad++; $display("FAIL abort_pc_done got=%b exp=00", rsp_done); end
      tick();
      mem_rsp_done = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_pc_idle busy got=%b exp=0", busy); end
      tick();
      #1;
      total++; if (mem_req_pc !== 32'h140 || gnt !== 2'b01) begin bad++; $display("FAIL abort_pc_regrant got=%h/%b exp=140/01", mem_req_pc, gnt); end
      mem_rsp_done = 1'b1;
      #1;
      total++; if (rsp_done !== 2'b01) begin bad++; $display("FAIL abort_pc_complete got=%b exp=01", rsp_done); end
      tick();
      req_en = 2'b00;
      mem_rsp_done = 1'b0;
   endtask

   task automatic test_reset_mid();
      req_en = 2'b01;
      req_pc[0] = 32'h300;
      tick();
      #1;
      total++; if (busy !== 1'b1 || gnt !== 2'b01) begin bad++; $display("FAIL rmid_busy got=%b/%b exp=1/01", busy, gnt); end
      rst = 1'b1;
      mem_rsp_done = 1'b1;
      #1;
      total++; if (rsp_done !== 2'b00) begin bad++; $display("FAIL rmid_done_discard got=%b exp=00", rsp_done); end
      tick();
      rst = 1'b0;
      mem_rsp_done = 1'b0;
      req_en = 2'b11;
      req_pc[1] = 32'h400;
      #1;
      total++; if (busy !== 1'b0 || gnt !== 2'b00 || mem_req_en !== 1'b0 || rsp_done !== 2'b00) begin bad++; $display("FAIL rmid_after busy=%b gnt=%b en=%b done=%b exp=0/00/0/00", busy, gnt, mem_req_en, rsp_done); end
      tick();
      #1;
      total++; if (gnt !== 2'b01 || mem_req_pc !== 32'h300) begin bad++; $display("FAIL rmid_ptr_zero got=%b/%h exp=01/300", gnt, mem_req_pc); end
      req_en = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_abort_en();
      test_abort_pc();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
